semaforo_controle: RTL and testbench

SEMAFORO_CONTROLE -- requirements
Module: semaforo_controle

---
 rtl/semaforo_controle.sv | 158 +++++++++++++++
 tb/tb_semaforo_controle.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/semaforo_controle.sv
// Traffic-light controller FSM: vehicle/pedestrian lamps, pedestrian request latch
// and load/clear strobes for the external 7 s, 5 s and 0.5 s timers.
module semaforo_controle (
  input  logic       clk,
  input  logic       rst,
  input  logic       botao_pedestre,
  input  logic       fim_7s,
  input  logic       fim_5s,
  input  logic       fim_05s,
  output logic       load_Reg7s,
  output logic       clear_Reg7s,
  output logic       load_Reg5s,
  output logic       clear_Reg5s,
  output logic       load_Reg05s,
  output logic       clear_Reg05s,
  output logic       carro_verde,
  output logic       carro_amarelo,
  output logic       carro_vermelho,
  output logic       pedestre_verde,
  output logic       pedestre_vermelho,
  output logic       pedido,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    VERDE    = 2'd0,
    AMARELO  = 2'd1,
    VERMELHO = 2'd2,
    PISCA    = 2'd3
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [2:0] meio_q, meio_d;
  logic       fase_q, fase_d;
  logic       pedido_q, pedido_d;

  // Next-state logic.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    estado_d = estado_q;
    meio_d   = meio_q;
    fase_d   = fase_q;
    pedido_d = pedido_q;

    unique case (estado_q)
      VERDE: begin
        if (botao_pedestre) pedido_d = 1'b1;
        if (fim_7s && (pedido_q || botao_pedestre)) estado_d = AMARELO;
      end
      AMARELO: begin
        if (botao_pedestre) pedido_d = 1'b1;
        if (fim_05s) begin
          if (meio_q == 3'd3) begin
            estado_d = VERMELHO;
            pedido_d = 1'b0;
          end else begin
            meio_d = meio_q + 3'd1;
          end
        end
      end
      VERMELHO: begin
        if (fim_5s) estado_d = PISCA;
      end
      PISCA: begin
        if (fim_05s) begin
          fase_d = ~fase_q;
          if (meio_q == 3'd5) estado_d = VERDE;
          else                meio_d   = meio_q + 3'd1;
        end
      end
      default: estado_d = VERDE;
    endcase

    // Every state starts its half-second count and blink phase fresh.
    if (estado_d != estado_q) begin
      meio_d = 3'd0;
      fase_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= VERDE;
      meio_q   <= 3'd0;
      fase_q   <= 1'b1;
      pedido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      meio_q   <= meio_d;
      fase_q   <= fase_d;
      pedido_q <= pedido_d;
    end
  end

  // Timer strobes are silenced while reset is held so no timer runs from a
  // state that has just been abandoned.
  always_comb begin
    load_Reg7s   = 1'b0;
    clear_Reg7s  = 1'b0;
    load_Reg5s   = 1'b0;
    clear_Reg5s  = 1'b0;
    load_Reg05s  = 1'b0;
    clear_Reg05s = 1'b0;

    if (rst) begin
      unique case (estado_q)
        VERDE: begin
          load_Reg7s  = 1'b1;
          clear_Reg7s = fim_7s && (pedido_q || botao_pedestre);
        end
        AMARELO, PISCA: begin
          load_Reg05s  = 1'b1;
          clear_Reg05s = fim_05s;
        end
        VERMELHO: begin
          load_Reg5s  = 1'b1;
          clear_Reg5s = fim_5s;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    carro_verde       = 1'b0;
    carro_amarelo     = 1'b0;
    carro_vermelho    = 1'b0;
    pedestre_verde    = 1'b0;
    pedestre_vermelho = 1'b0;

    unique case (estado_q)
      VERDE: begin
        carro_verde       = 1'b1;
        pedestre_vermelho = 1'b1;
      end
      AMARELO: begin
        carro_amarelo     = 1'b1;
        pedestre_vermelho = 1'b1;
      end
      VERMELHO: begin
        carro_vermelho = 1'b1;
        pedestre_verde = 1'b1;
      end
      PISCA: begin
        carro_vermelho    = 1'b1;
        pedestre_vermelho = fase_q;
      end
      default: ;
    endcase
  end

  assign pedido = pedido_q;
  assign estado = estado_q;

endmodule

// File: tb/tb_semaforo_controle.sv
// Directed bench for semaforo_controle: table of per-cycle vectors covering a full
// light cycle, plus hand sequences for reset, VERDE hold and async reset in PISCA.
module tb_semaforo_controle;

  logic       clk = 1'b0;
  logic       rst;
  logic       botao_pedestre, fim_7s, fim_5s, fim_05s;
  logic       load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s;
  logic       carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho;
  logic       pedido;
  logic [1:0] estado;

  int pass_cnt  = 0;
  int total_cnt = 0;

  semaforo_controle dut (
    .clk               (clk),
    .rst               (rst),
    .botao_pedestre    (botao_pedestre),
    .fim_7s            (fim_7s),
    .fim_5s            (fim_5s),
    .fim_05s           (fim_05s),
    .load_Reg7s        (load_Reg7s),
    .clear_Reg7s       (clear_Reg7s),
    .load_Reg5s        (load_Reg5s),
    .clear_Reg5s       (clear_Reg5s),
    .load_Reg05s       (load_Reg05s),
    .clear_Reg05s      (clear_Reg05s),
    .carro_verde       (carro_verde),
    .carro_amarelo     (carro_amarelo),
    .carro_vermelho    (carro_vermelho),
    .pedestre_verde    (pedestre_verde),
    .pedestre_vermelho (pedestre_vermelho),
    .pedido            (pedido),
    .estado            (estado)
  );

  always #5 clk = ~clk;

  // {b, f7, f5, f05} inputs; ctrl = {ld7, cl7, ld5, cl5, ld05, cl05};
  // lamps = {carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho}
  typedef struct {
    logic [3:0] in;
    logic [1:0] est;
    logic       ped;
    logic [5:0] ctrl;
    logic [4:0] lamps;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] in, input logic [1:0] est, input logic ped,
                              input logic [5:0] ctrl, input logic [4:0] lamps);
    vec_t v;
    v.in = in; v.est = est; v.ped = ped; v.ctrl = ctrl; v.lamps = lamps;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [5:0] ctrl_now();
    return {load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s};
  endfunction

  function automatic logic [4:0] lamps_now();
    return {carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho};
  endfunction

  task automatic drive(input logic [3:0] in);
    {botao_pedestre, fim_7s, fim_5s, fim_05s} = in;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full cycle: request in VERDE, yellow 4 x 0.5 s, red, blink 6 x 0.5 s, back to green.
    vecs[0]  = mk(4'b1000, 2'd0, 1'b0, 6'b100000, 5'b10001);
    vecs[1]  = mk(4'b0000, 2'd0, 1'b1, 6'b100000, 5'b10001);
    vecs[2]  = mk(4'b0100, 2'd0, 1'b1, 6'b110000, 5'b10001);
    vecs[3]  = mk(4'b0000, 2'd1, 1'b1, 6'b000010, 5'b01001);
    vecs[4]  = mk(4'b0001, 2'd1, 1'b1, 6'b000011, 5'b01001);
    vecs[5]  = mk(4'b0000, 2'd1, 1'b1, 6'b000010, 5'b01001);
    vecs[6]  = mk(4'b0001, 2'd1, 1'b1, 6'b000011, 5'b01001);
    vecs[7]  = mk(4'b0001, 2'd1, 1'b1, 6'b000011, 5'b01001);
    vecs[8]  = mk(4'b0001, 2'd1, 1'b1, 6'b000011, 5'b01001);
    vecs[9]  = mk(4'b1000, 2'd2, 1'b0, 6'b001000, 5'b00110);
    vecs[10] = mk(4'b0010, 2'd2, 1'b0, 6'b001100, 5'b00110);
    vecs[11] = mk(4'b0000, 2'd3, 1'b0, 6'b000010, 5'b00101);
    vecs[12] = mk(4'b0001, 2'd3, 1'b0, 6'b000011, 5'b00101);
    vecs[13] = mk(4'b0001, 2'd3, 1'b0, 6'b000011, 5'b00100);
    vecs[14] = mk(4'b0000, 2'd3, 1'b0, 6'b000010, 5'b00101);
    vecs[15] = mk(4'b0001, 2'd3, 1'b0, 6'b000011, 5'b00101);
    vecs[16] = mk(4'b0001, 2'd3, 1'b0, 6'b000011, 5'b00100);
    vecs[17] = mk(4'b0001, 2'd3, 1'b0, 6'b000011, 5'b00101);
    vecs[18] = mk(4'b0001, 2'd3, 1'b0, 6'b000011, 5'b00100);
    vecs[19] = mk(4'b0000, 2'd0, 1'b0, 6'b100000, 5'b10001);
    // Button and fim_7s together with no latched request.
    vecs[20] = mk(4'b1100, 2'd0, 1'b0, 6'b110000, 5'b10001);
    vecs[21] = mk(4'b0000, 2'd1, 1'b1, 6'b000010, 5'b01001);
    vecs[22] = mk(4'b1000, 2'd1, 1'b1, 6'b000010, 5'b01001);

    rst = 1'b0;
    drive(4'b0000);
    #3;
    check("reset estado", 32'(estado), 32'd0);
    check("reset pedido", 32'(pedido), 32'd0);
    check("reset ctrl", 32'(ctrl_now()), 32'b000000);
    check("reset lamps", 32'(lamps_now()), 32'b10001);

    @(posedge clk);
    #1;
    rst = 1'b1;

    // fim_7s held without a request keeps VERDE.
    drive(4'b0100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d estado/ld7/cl7", i),
            32'({estado, load_Reg7s, clear_Reg7s}), 32'b0010);
      next_cycle();
    end

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in);
      @(negedge clk);
      check($sformatf("row%0d estado", i), 32'(estado), 32'(vecs[i].est));
      check($sformatf("row%0d pedido", i), 32'(pedido), 32'(vecs[i].ped));
      check($sformatf("row%0d ctrl", i), 32'(ctrl_now()), 32'(vecs[i].ctrl));
      check($sformatf("row%0d lamps", i), 32'(lamps_now()), 32'(vecs[i].lamps));
      next_cycle();
    end

    // Walk from AMARELO to PISCA and take one blink step.
    drive(4'b0001);
    repeat (4) next_cycle();
    check("to vermelho estado", 32'(estado), 32'd2);
    drive(4'b0010);
    next_cycle();
    check("to pisca estado", 32'(estado), 32'd3);
    drive(4'b0001);
    next_cycle();
    drive(4'b0000);
    #1;
    check("pisca fase0 estado", 32'(estado), 32'd3);
    check("pisca fase0 ped_vermelho", 32'(pedestre_vermelho), 32'd0);

    // Async reset between edges with every input active.
    drive(4'b1111);
    #1;
    rst = 1'b0;
    #1;
    check("async rst estado", 32'(estado), 32'd0);
    check("async rst fase", 32'(dut.fase_q), 32'd1);
    check("async rst meio", 32'(dut.meio_q), 32'd0);
    check("async rst pedido", 32'(pedido), 32'd0);
    check("async rst ctrl", 32'(ctrl_now()), 32'b000000);
    check("async rst lamps", 32'(lamps_now()), 32'b10001);
    next_cycle();
    check("held rst ctrl", 32'(ctrl_now()), 32'b000000);
    check("held rst estado", 32'(estado), 32'd0);

    drive(4'b0000);
    rst = 1'b1;
    @(negedge clk);
    check("release ctrl", 32'(ctrl_now()), 32'b100000);
    check("release pedido", 32'(pedido), 32'd0);
    next_cycle();
    check("release estado", 32'(estado), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
